// File: rtl/cmp_search.sv
// rtl/cmp_search.sv - successive-approximation search controller driving a magnitude comparator
// Resolves a hidden comparator operand MSB-first, one trial bit per compare step.
module cmp_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         aeqb,
  input  logic                         agtb,
  input  logic                         altb,
  output logic [WIDTH-1:0]             guess,
  output logic [WIDTH-1:0]             result,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   steps
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int SW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] upd;
  logic             onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      wait_q   <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      wait_q   <= wait_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  assign onehot = (aeqb + agtb + altb) == 2'd1;

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    steps_d  = steps_q;
    err_d    = err_q;
    upd      = guess_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d            = PROBE;
          guess_d            = '0;
          guess_d[WIDTH-1]   = 1'b1;
          idx_d              = IW'(WIDTH - 1);
          wait_d             = WW'(SETTLE);
          steps_d            = '0;
          err_d              = 1'b0;
        end
      end
      PROBE: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          steps_d = steps_q + 1'b1;
          if (!onehot) begin
            state_d  = DONE;
            err_d    = 1'b1;
            result_d = '0;
          end else if (aeqb) begin
            state_d  = DONE;
            result_d = guess_q;
          end else begin
            // Target below the trial means this bit must be zero.
            if (altb) upd[idx_q] = 1'b0;
            if (idx_q == '0) begin
              state_d  = DONE;
              guess_d  = upd;
              result_d = upd;
            end else begin
              upd[idx_q - 1'b1] = 1'b1;
              guess_d = upd;
              idx_d   = idx_q - 1'b1;
              wait_d  = WW'(SETTLE);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == PROBE);
    done = (state_q == DONE);
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_cmp_search.sv
// tb/tb_cmp_search.sv - directed bench for cmp_search against an ideal comparator model
// Two instances: SETTLE=0 (sel 0) and SETTLE=2 (sel 1).
module tb_cmp_search;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] target0 = '0, target1 = '0;
  logic       bad = 1'b0;

  logic [3:0] guess0, result0, guess1, result1;
  logic       busy0, done0, err0, busy1, done1, err1;
  logic [2:0] steps0, steps1;
  logic       aeqb0, agtb0, altb0, aeqb1, agtb1, altb1;

  int npass = 0;
  int ntotal = 0;
  int cur = 0;
  int eg[4];

  always #5 clk = ~clk;

  assign aeqb0 = bad ? 1'b0 : (target0 == guess0);
  assign agtb0 = bad ? 1'b1 : (target0 >  guess0);
  assign altb0 = bad ? 1'b1 : (target0 <  guess0);
  assign aeqb1 = (target1 == guess1);
  assign agtb1 = (target1 >  guess1);
  assign altb1 = (target1 <  guess1);

  cmp_search #(.WIDTH(4), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .aeqb(aeqb0), .agtb(agtb0), .altb(altb0),
    .guess(guess0), .result(result0), .busy(busy0),
    .done(done0), .err(err0), .steps(steps0)
  );

  cmp_search #(.WIDTH(4), .SETTLE(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .aeqb(aeqb1), .agtb(agtb1), .altb(altb1),
    .guess(guess1), .result(result1), .busy(busy1),
    .done(done1), .err(err1), .steps(steps1)
  );

  logic [3:0] og, ores;
  logic       obusy, odone, oerr;
  logic [2:0] osteps;
  assign og     = cur ? guess1  : guess0;
  assign ores   = cur ? result1 : result0;
  assign obusy  = cur ? busy1   : busy0;
  assign odone  = cur ? done1   : done0;
  assign oerr   = cur ? err1    : err0;
  assign osteps = cur ? steps1  : steps0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_start(input bit v);
    if (cur) start1 = v; else start0 = v;
  endtask

  task automatic run_search(input int sel, input int tgt, input int ng, input int exp_res,
                            input int exp_steps, input int exp_err, input int settle,
                            input int bad_at, input bit poke);
    int n;
    cur = sel;
    if (sel) target1 = 4'(tgt); else target0 = 4'(tgt);
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    check($sformatf("t%0d busy_after_start", tgt), obusy, 1);
    n = 0;
    while (!odone && n < 60) begin
      if (n / (settle + 1) < ng)
        check($sformatf("t%0d guess_c%0d", tgt, n), og, eg[n / (settle + 1)]);
      bad = (n == bad_at);
      set_start(poke && (n == 4 || n == 5));
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
    set_start(1'b0);
    check($sformatf("t%0d latency", tgt), n, exp_steps * (settle + 1));
    check($sformatf("t%0d done", tgt), odone, 1);
    check($sformatf("t%0d busy_in_done", tgt), obusy, 0);
    check($sformatf("t%0d result", tgt), ores, exp_res);
    check($sformatf("t%0d steps", tgt), osteps, exp_steps);
    check($sformatf("t%0d err", tgt), oerr, exp_err);
    if (poke) set_start(1'b1);
    @(negedge clk);
    check($sformatf("t%0d done_one_cycle", tgt), odone, 0);
    check($sformatf("t%0d start_in_done_ignored", tgt), obusy, 0);
    set_start(1'b0);
    check($sformatf("t%0d result_held", tgt), ores, exp_res);
  endtask

  initial begin
    int saw_done;
    repeat (2) @(negedge clk);
    check("rst guess0", guess0, 0);
    check("rst result0", result0, 0);
    check("rst busy0", busy0, 0);
    check("rst done0", done0, 0);
    check("rst err0", err0, 0);
    check("rst steps0", steps0, 0);
    check("rst guess1", guess1, 0);
    check("rst busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    eg = '{8, 12, 10, 11};
    run_search(0, 11, 4, 11, 4, 0, 0, -1, 0);
    eg = '{8, 0, 0, 0};
    run_search(0, 8, 1, 8, 1, 0, 0, -1, 0);
    eg = '{8, 4, 2, 1};
    run_search(0, 0, 4, 0, 4, 0, 0, -1, 0);
    eg = '{8, 12, 14, 15};
    run_search(0, 15, 4, 15, 4, 0, 0, -1, 1);
    eg = '{8, 4, 6, 5};
    run_search(1, 5, 4, 5, 4, 0, 2, -1, 1);

    // Reset mid-search on both instances.
    cur = 0;
    target0 = 4'd11;
    target1 = 4'd9;
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst guess0", guess0, 0);
    check("arst result0", result0, 0);
    check("arst busy0", busy0, 0);
    check("arst steps0", steps0, 0);
    check("arst err0", err0, 0);
    check("arst done0", done0, 0);
    check("arst guess1", guess1, 0);
    check("arst result1", result1, 0);
    check("arst busy1", busy1, 0);
    saw_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done0 || done1) saw_done = 1;
    end
    check("arst no_done", saw_done, 0);

    eg = '{8, 4, 6, 0};
    run_search(0, 6, 3, 6, 3, 0, 0, -1, 0);
    eg = '{8, 12, 0, 0};
    run_search(0, 11, 2, 0, 2, 1, 0, 1, 0);
    eg = '{8, 12, 10, 11};
    run_search(0, 11, 4, 11, 4, 0, 0, -1, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/cmp_search.md
# cmp_search

- Successive-approximation search controller that drives the operand side of a magnitude comparator and consumes its equal/greater/less flags.
- The comparator's `a` input carries a hidden target value; this block drives `b` with trial values.
- Resolves the target MSB-first in at most WIDTH compare steps, then reports the result, the step count and a flag-consistency error.
- Sits beside the 4-bit comparator as its initiator.

## Interface
- WIDTH, 4: operand width; must match the comparator.
- SETTLE, 0: extra wait cycles after each new guess before flags are sampled (0 = combinational comparator).
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a search; accepted only in IDLE.
- aeqb  input  1  comparator flag: target == guess.
- agtb  input  1  comparator flag: target > guess.
- altb  input  1  comparator flag: target < guess.
- guess  output  WIDTH  registered trial value driven to comparator `b`.
- result  output  WIDTH  resolved target; held until the next accepted start.
- busy  output  1  high while in PROBE.
- done  output  1  one-cycle pulse when a search ends.
- err  output  1  set with done when flags were not one-hot; held until the next start.
- steps  output  $clog2(WIDTH+1)  number of flag samples taken in the last search.

## Operation
- States: IDLE, PROBE, DONE.
- Internal registers:
  - idx: current bit position, WIDTH-1 down to 0.
  - wait counter: 0..SETTLE.
- IDLE:
  - On start=1 load guess = 1 << (WIDTH-1), idx = WIDTH-1, wait = SETTLE, steps = 0, err = 0.
  - Then go to PROBE.
- PROBE, wait != 0: decrement wait; guess held.
- PROBE, wait == 0: sample flags and increment steps.
  - Flags not exactly one-hot: go to DONE with err=1, result=0.
  - aeqb (highest priority): go to DONE with result=guess.
  - altb: clear guess[idx].
  - agtb: keep guess[idx].
  - If idx == 0 after the update: go to DONE with result = updated guess.
  - Otherwise set guess[idx-1], decrement idx, reload wait = SETTLE, stay in PROBE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE and in PROBE.
- guess holds its last value in IDLE/DONE.
- Reset values: guess=0, result=0, busy=0, done=0, err=0, steps=0, state IDLE.
- Reset asserted mid-search aborts immediately: no done pulse, all outputs return to reset values.

## Timing
- start sampled at edge E0. From E0:
  - state=PROBE, busy=1, new guess valid.
- Flags are sampled at edges E0+k*(SETTLE+1), k=1..steps.
- The final sample edge also loads result, steps and err, and enters DONE.
- From that edge:
  - done=1, busy=0 for one cycle.
  - IDLE at the following edge.
- Latency from start edge to done high: steps*(SETTLE+1) cycles; maximum WIDTH*(SETTLE+1).
- Back-to-back searches:
  - start high during the done cycle is ignored.
  - The earliest accepted start is the first cycle in IDLE.
- Guess changes only on the edge after a sample; it is stable for SETTLE+1 cycles per step.

## Test plan
- WIDTH=4, SETTLE=0, target 11 (ideal comparator model):
  - guesses 8, 12, 10, 11.
  - result=11, steps=4, err=0, done one cycle, 4 cycles after the start edge.
- Target 8:
  - aeqb on first sample.
  - result=8, steps=1, done 1 cycle after start.
- Target 0:
  - guesses 8, 4, 2, 1, all altb.
  - result=0, steps=4, done without aeqb.
- Target 15:
  - guesses 8, 12, 14, 15.
  - result=15, steps=4.
- SETTLE=2, target 5:
  - guesses 8, 4, 6, 5, each held exactly 3 cycles.
  - done 12 cycles after start.
  - start pulses while busy are ignored.
- Robustness:
  - Force agtb=altb=1 on second sample → done with err=1, result=0, steps=2.
  - Assert rst_n low mid-search → all outputs 0 asynchronously; no done pulse.
  - Next start proceeds normally.
